fdtd_hy_update: RTL and testbench



---
 rtl/fdtd_pkg.sv | 23 ++
 rtl/fdtd_hy_update_if.sv | 44 ++++
 rtl/fdtd_round_sat.sv | 39 +++
 rtl/fdtd_hy_update.sv | 171 +++++++++++++++++
 tb/tb_fdtd_hy_update.sv | 369 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fdtd_pkg.sv
// Shared fixed-point types, limits and FSM states for the FDTD field-update engines.
package fdtd_pkg;

  localparam int FXP_W    = 32;
  localparam int FXP_FRAC = 16;
  localparam int CNT_W    = 15;
  localparam int FXP_WIDE = 2 * FXP_W + 2;

  typedef logic signed [FXP_W-1:0]    fxp_t;
  typedef logic signed [FXP_WIDE-1:0] fxp_wide_t;

  localparam fxp_t FXP_MAX = 32'sh7FFF_FFFF;
  localparam fxp_t FXP_MIN = 32'sh8000_0000;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_PRIME = 3'd1,
    ST_RUN   = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } hy_state_e;

endpackage

// File: rtl/fdtd_hy_update_if.sv
// Control, coefficient and stream signals of the Hy update engine.
interface fdtd_hy_update_if
  import fdtd_pkg::*;
#(
  parameter int DATA_WIDTH = FXP_W,
  parameter int CNT_WIDTH  = CNT_W
);

  logic                  start_i;
  logic [CNT_WIDTH-1:0]  n_cells_i;
  logic [DATA_WIDTH-1:0] chyh_i;
  logic [DATA_WIDTH-1:0] chyez_i;

  logic                  ez_valid_i;
  logic [DATA_WIDTH-1:0] ez_data_i;
  logic                  ez_ready_o;

  logic                  hy_valid_i;
  logic [DATA_WIDTH-1:0] hy_data_i;
  logic                  hy_ready_o;

  logic                  out_valid_o;
  logic [DATA_WIDTH-1:0] out_data_o;
  logic                  out_ready_i;

  logic                  busy_o;
  logic                  done_o;
  logic                  ovf_o;

  modport slave (
    input  start_i, n_cells_i, chyh_i, chyez_i,
    input  ez_valid_i, ez_data_i, hy_valid_i, hy_data_i, out_ready_i,
    output ez_ready_o, hy_ready_o, out_valid_o, out_data_o,
    output busy_o, done_o, ovf_o
  );

  modport master (
    output start_i, n_cells_i, chyh_i, chyez_i,
    output ez_valid_i, ez_data_i, hy_valid_i, hy_data_i, out_ready_i,
    input  ez_ready_o, hy_ready_o, out_valid_o, out_data_o,
    input  busy_o, done_o, ovf_o
  );

endinterface

// File: rtl/fdtd_round_sat.sv
// Round half toward +inf, drop the fraction bits and clamp to the signed sample range.
module fdtd_round_sat
  import fdtd_pkg::*;
#(
  parameter int DATA_WIDTH = FXP_W,
  parameter int FRAC_BITS  = FXP_FRAC,
  parameter int SUM_WIDTH  = 2 * DATA_WIDTH + 2
) (
  input  logic signed [SUM_WIDTH-1:0]  sum,
  output logic signed [DATA_WIDTH-1:0] res,
  output logic                         ovf
);

  localparam logic signed [SUM_WIDTH-1:0] HALF =
    {{(SUM_WIDTH-FRAC_BITS){1'b0}}, 1'b1, {(FRAC_BITS-1){1'b0}}};
  localparam logic signed [SUM_WIDTH-1:0] MAX_W =
    {{(SUM_WIDTH-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [SUM_WIDTH-1:0] MIN_W =
    {{(SUM_WIDTH-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

  logic signed [SUM_WIDTH-1:0] biased;
  logic signed [SUM_WIDTH-1:0] shifted;

  // Sum has two spare headroom bits, so the rounding bias can never wrap.
  always_comb begin
    biased  = sum + HALF;
    shifted = biased >>> FRAC_BITS;
    res     = shifted[DATA_WIDTH-1:0];
    ovf     = 1'b0;
    if (shifted > MAX_W) begin
      res = {1'b0, {(DATA_WIDTH-1){1'b1}}};
      ovf = 1'b1;
    end else if (shifted < MIN_W) begin
      res = {1'b1, {(DATA_WIDTH-1){1'b0}}};
      ovf = 1'b1;
    end
  end

endmodule

// File: rtl/fdtd_hy_update.sv
// Streaming Hy update: Hy_n[i] = chyh*Hy[i] + chyez*(Ez[i+1]-Ez[i]), 3-stage pipeline.
//
// state    | meaning
// ST_IDLE  | waiting for start_i
// ST_PRIME | take Ez[0] into ez_prev
// ST_RUN   | joint Ez/Hy transfers until N taken
// ST_DRAIN | wait for the pipeline and last output handshake
// ST_DONE  | one-cycle done pulse
module fdtd_hy_update
  import fdtd_pkg::*;
#(
  parameter int DATA_WIDTH = FXP_W,
  parameter int FRAC_BITS  = FXP_FRAC,
  parameter int CNT_WIDTH  = CNT_W
) (
  input  logic              clk,
  input  logic              rst_n,
  fdtd_hy_update_if.slave   bus
);

  localparam int DW1   = DATA_WIDTH + 1;
  localparam int PW_HY = 2 * DATA_WIDTH;
  localparam int PW_EZ = 2 * DATA_WIDTH + 1;
  localparam int WW    = 2 * DATA_WIDTH + 2;

  hy_state_e state, state_nxt;

  logic [CNT_WIDTH-1:0]         rem;
  logic signed [DATA_WIDTH-1:0] chyh_q, chyez_q, ez_prev;

  logic adv, xfer, prime_xfer, run_last, pipe_drained, start_run, start_any;
  logic ez_ready, hy_ready, busy, done;

  logic                         s1_valid, s2_valid, out_valid;
  logic signed [DW1-1:0]        s1_diff;
  logic signed [DATA_WIDTH-1:0] s1_hy;
  logic signed [PW_HY-1:0]      s2_p_hy;
  logic signed [PW_EZ-1:0]      s2_p_ez;
  logic signed [DATA_WIDTH-1:0] out_data;
  logic                         ovf;

  logic signed [PW_HY-1:0]      chyh_ext, hy_ext;
  logic signed [PW_EZ-1:0]      chyez_ext, diff_ext;
  logic signed [WW-1:0]         sum;
  logic signed [DATA_WIDTH-1:0] sat_data;
  logic                         sat_ovf;

  assign adv          = !(out_valid && !bus.out_ready_i);
  assign start_any    = (state == ST_IDLE) && bus.start_i;
  assign start_run    = start_any && (bus.n_cells_i != '0);
  assign prime_xfer   = (state == ST_PRIME) && bus.ez_valid_i;
  assign xfer         = (state == ST_RUN) && bus.ez_valid_i && bus.hy_valid_i && adv;
  assign run_last     = xfer && (rem == CNT_WIDTH'(1));
  assign pipe_drained = !s1_valid && !s2_valid && (!out_valid || bus.out_ready_i);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Next-state decode and handshake/status outputs.
  always_comb begin
    state_nxt = state;
    ez_ready  = 1'b0;
    hy_ready  = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;
    case (state)
      ST_IDLE: begin
        busy = 1'b0;
        if (bus.start_i) state_nxt = (bus.n_cells_i == '0) ? ST_DONE : ST_PRIME;
      end
      ST_PRIME: begin
        ez_ready = 1'b1;
        if (bus.ez_valid_i) state_nxt = ST_RUN;
      end
      ST_RUN: begin
        ez_ready = xfer;
        hy_ready = xfer;
        if (run_last) state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (pipe_drained) state_nxt = ST_DONE;
      end
      ST_DONE: begin
        done      = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Run parameters, remaining-transfer down-counter and held Ez sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem     <= '0;
      chyh_q  <= '0;
      chyez_q <= '0;
      ez_prev <= '0;
    end else begin
      if (start_run) begin
        rem     <= bus.n_cells_i;
        chyh_q  <= bus.chyh_i;
        chyez_q <= bus.chyez_i;
      end else if (xfer) begin
        rem <= rem - CNT_WIDTH'(1);
      end
      if (prime_xfer || xfer) ez_prev <= bus.ez_data_i;
    end
  end

  assign chyh_ext  = {{DATA_WIDTH{chyh_q[DATA_WIDTH-1]}}, chyh_q};
  assign hy_ext    = {{DATA_WIDTH{s1_hy[DATA_WIDTH-1]}}, s1_hy};
  assign chyez_ext = {{DW1{chyez_q[DATA_WIDTH-1]}}, chyez_q};
  assign diff_ext  = {{DATA_WIDTH{s1_diff[DW1-1]}}, s1_diff};
  assign sum       = {{2{s2_p_hy[PW_HY-1]}}, s2_p_hy} + {s2_p_ez[PW_EZ-1], s2_p_ez};

  fdtd_round_sat #(
    .DATA_WIDTH (DATA_WIDTH),
    .FRAC_BITS  (FRAC_BITS),
    .SUM_WIDTH  (WW)
  ) u_round_sat (
    .sum (sum),
    .res (sat_data),
    .ovf (sat_ovf)
  );

  // Three pipeline stages sharing one stall enable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid  <= 1'b0;
      s1_diff   <= '0;
      s1_hy     <= '0;
      s2_valid  <= 1'b0;
      s2_p_hy   <= '0;
      s2_p_ez   <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (adv) begin
      s1_valid <= xfer;
      if (xfer) begin
        s1_diff <= {bus.ez_data_i[DATA_WIDTH-1], bus.ez_data_i} - {ez_prev[DATA_WIDTH-1], ez_prev};
        s1_hy   <= bus.hy_data_i;
      end
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_p_hy <= chyh_ext * hy_ext;
        s2_p_ez <= chyez_ext * diff_ext;
      end
      out_valid <= s2_valid;
      if (s2_valid) out_data <= sat_data;
    end
  end

  // Sticky clamp flag, cleared by an accepted start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                          ovf <= 1'b0;
    else if (start_any)                  ovf <= 1'b0;
    else if (adv && s2_valid && sat_ovf) ovf <= 1'b1;
  end

  assign bus.ez_ready_o  = ez_ready;
  assign bus.hy_ready_o  = hy_ready;
  assign bus.out_valid_o = out_valid;
  assign bus.out_data_o  = out_data;
  assign bus.busy_o      = busy;
  assign bus.done_o      = done;
  assign bus.ovf_o       = ovf;

endmodule

// File: tb/tb_fdtd_hy_update.sv
// Scoreboard bench for fdtd_hy_update with an arithmetic reference model.
module tb_fdtd_hy_update;

  localparam int DW = 32;
  localparam int CW = 15;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fdtd_hy_update_if #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) bus();

  fdtd_hy_update #(.DATA_WIDTH(DW), .FRAC_BITS(16), .CNT_WIDTH(CW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [31:0] exp_q[$];
  logic [31:0] ez_vec[$];
  logic [31:0] hy_vec[$];
  int unsigned last_hs_cyc = 0;
  int n_out_seen = 0;
  bit stall_armed = 1'b0;
  int stall_after = 0;
  int ready_pct = 100;
  logic [31:0] held_data = '0;
  bit was_stalled = 1'b0;
  int stall_left = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference: exact integer arithmetic, floor(x + 1/2) rounding, then clamp.
  function automatic logic [31:0] ref_hy(input logic [31:0] chyh, input logic [31:0] chyez,
                                         input logic [31:0] hy, input logic [31:0] ez_lo,
                                         input logic [31:0] ez_hi, output bit ov);
    logic signed [127:0] a, h, c, d, s, t, q;
    a = 128'($signed(chyh));
    h = 128'($signed(hy));
    c = 128'($signed(chyez));
    d = 128'($signed(ez_hi)) - 128'($signed(ez_lo));
    s = a * h + c * d;
    t = s + 128'sd32768;
    q = t / 128'sd65536;
    if ((t % 128'sd65536) != 0 && t < 0) q = q - 1;
    ov = 1'b0;
    if (q > 128'sd2147483647) begin
      ov = 1'b1;
      return 32'h7FFF_FFFF;
    end
    if (q < -128'sd2147483648) begin
      ov = 1'b1;
      return 32'h8000_0000;
    end
    return q[31:0];
  endfunction

  // Monitor: drives out_ready, pops the scoreboard on each output handshake.
  initial begin
    logic [31:0] e;
    bus.out_ready_i = 1'b0;
    forever begin
      @(negedge clk);
      if (stall_left > 0) begin
        bus.out_ready_i = 1'b0;
        stall_left--;
      end else begin
        bus.out_ready_i = ($urandom_range(99) < ready_pct);
      end
      #4;
      if (!rst_n) begin
        was_stalled = 1'b0;
        continue;
      end
      if (was_stalled) begin
        check("stall_valid_hold", bus.out_valid_o, 1);
        check("stall_data_hold", bus.out_data_o, held_data);
      end
      if (bus.out_valid_o && !bus.out_ready_i) begin
        check("stall_no_ez", bus.ez_ready_o, 0);
        check("stall_no_hy", bus.hy_ready_o, 0);
        was_stalled = 1'b1;
        held_data = bus.out_data_o;
      end else begin
        was_stalled = 1'b0;
      end
      if (bus.hy_ready_o) check("lone_valid", bus.ez_valid_i && bus.hy_valid_i, 1);
      if (bus.out_valid_o && bus.out_ready_i) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_out: got 0x%0h, required no output", bus.out_data_o);
        end else begin
          e = exp_q.pop_front();
          check("hy_out", bus.out_data_o, e);
        end
        last_hs_cyc = cyc;
        n_out_seen++;
        if (stall_armed && n_out_seen == stall_after) begin
          stall_left = 5;
          stall_armed = 1'b0;
        end
      end
    end
  end

  task automatic drive_ez(input int cnt, input int gap_pct, output bit ok);
    int idx = 0;
    int guard = 0;
    ok = 1'b1;
    while (idx < cnt) begin
      @(negedge clk);
      bus.ez_valid_i = ($urandom_range(99) >= gap_pct);
      bus.ez_data_i  = bus.ez_valid_i ? ez_vec[idx] : $urandom;
      #4;
      if (bus.ez_valid_i && bus.ez_ready_o) idx++;
      guard++;
      if (guard > 2000) begin
        ok = 1'b0;
        break;
      end
    end
    @(negedge clk);
    bus.ez_valid_i = 1'b0;
  endtask

  task automatic drive_hy(input int cnt, input int gap_pct, output bit ok);
    int idx = 0;
    int guard = 0;
    ok = 1'b1;
    while (idx < cnt) begin
      @(negedge clk);
      bus.hy_valid_i = ($urandom_range(99) >= gap_pct);
      bus.hy_data_i  = bus.hy_valid_i ? hy_vec[idx] : $urandom;
      #4;
      if (bus.hy_valid_i && bus.hy_ready_o) idx++;
      guard++;
      if (guard > 2000) begin
        ok = 1'b0;
        break;
      end
    end
    @(negedge clk);
    bus.hy_valid_i = 1'b0;
  endtask

  task automatic fill(input int n, input bit wide);
    ez_vec.delete();
    hy_vec.delete();
    for (int i = 0; i <= n; i++)
      ez_vec.push_back(wide ? $urandom : $urandom_range(32'h7FFFF) - 32'h40000);
    for (int i = 0; i < n; i++)
      hy_vec.push_back(wide ? $urandom : $urandom_range(32'h7FFFF) - 32'h40000);
  endtask

  task automatic do_run(input int n, input logic [31:0] chyh, input logic [31:0] chyez,
                        input int gap_pct, input bit inject);
    bit ok_e, ok_h, ov, got;
    bit exp_ov = 1'b0;
    int unsigned dcyc = 0;
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(ref_hy(chyh, chyez, hy_vec[i], ez_vec[i], ez_vec[i+1], ov));
      exp_ov |= ov;
    end
    @(negedge clk);
    bus.start_i   = 1'b1;
    bus.n_cells_i = CW'(n);
    bus.chyh_i    = chyh;
    bus.chyez_i   = chyez;
    @(negedge clk);
    bus.start_i   = 1'b0;
    bus.n_cells_i = CW'($urandom);
    bus.chyh_i    = $urandom;
    bus.chyez_i   = $urandom;
    #1;
    check("busy_after_start", bus.busy_o, 1);
    check("ovf_cleared", bus.ovf_o, 0);
    fork
      drive_ez(n + 1, gap_pct, ok_e);
      drive_hy(n, gap_pct, ok_h);
      begin
        if (inject) begin
          repeat (5) @(negedge clk);
          bus.start_i   = 1'b1;
          bus.n_cells_i = CW'(3);
          bus.chyh_i    = $urandom;
          bus.chyez_i   = $urandom;
          @(negedge clk);
          bus.start_i = 1'b0;
        end
      end
    join
    check("ez_stream_timeout", ok_e, 1);
    check("hy_stream_timeout", ok_h, 1);
    got = 1'b0;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      #4;
      if (bus.done_o) begin
        got = 1'b1;
        dcyc = cyc;
        break;
      end
    end
    check("done_seen", got, 1);
    if (got) check("done_timing", dcyc, last_hs_cyc + 1);
    @(negedge clk);
    #4;
    check("done_one_cycle", bus.done_o, 0);
    check("busy_after_done", bus.busy_o, 0);
    check("scoreboard_empty", exp_q.size(), 0);
    check("ovf_flag", bus.ovf_o, exp_ov);
    exp_q.delete();
  endtask

  // Watchdog for any unbounded hang.
  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout, required completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int hs;
    bus.start_i    = 1'b0;
    bus.n_cells_i  = '0;
    bus.chyh_i     = '0;
    bus.chyez_i    = '0;
    bus.ez_valid_i = 1'b0;
    bus.ez_data_i  = '0;
    bus.hy_valid_i = 1'b0;
    bus.hy_data_i  = '0;

    #12;
    check("rst_ez_ready", bus.ez_ready_o, 0);
    check("rst_hy_ready", bus.hy_ready_o, 0);
    check("rst_out_valid", bus.out_valid_o, 0);
    check("rst_out_data", bus.out_data_o, 0);
    check("rst_busy", bus.busy_o, 0);
    check("rst_done", bus.done_o, 0);
    check("rst_ovf", bus.ovf_o, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Basic stream with hand-computed results.
    ez_vec = '{32'h0, 32'h10000, 32'h30000, 32'h30000};
    hy_vec = '{32'h10000, 32'h10000, 32'h10000};
    check("ref_basic0", ref_hy(32'h10000, 32'h8000, 32'h10000, 32'h0, 32'h10000, hs[0]), 32'h18000);
    do_run(3, 32'h0001_0000, 32'h0000_8000, 0, 1'b0);

    // Rounding: +0.5 -> 1, -0.5 -> 0.
    ez_vec = '{32'h0, 32'h1, 32'h0};
    hy_vec = '{$urandom, $urandom};
    do_run(2, 32'h0, 32'h8000, 0, 1'b0);

    // N=0: done the cycle after start, no ready; start during DONE ignored.
    @(negedge clk);
    bus.start_i   = 1'b1;
    bus.n_cells_i = '0;
    #4;
    check("n0_ez_ready_idle", bus.ez_ready_o, 0);
    @(negedge clk);
    bus.start_i   = 1'b1;
    bus.n_cells_i = CW'(2);
    #4;
    check("n0_done", bus.done_o, 1);
    check("n0_ez_ready", bus.ez_ready_o, 0);
    check("n0_hy_ready", bus.hy_ready_o, 0);
    @(negedge clk);
    bus.start_i = 1'b0;
    #4;
    check("start_in_done_ignored", bus.busy_o, 0);
    check("n0_done_pulse", bus.done_o, 0);
    check("n0_hy_ready_after", bus.hy_ready_o, 0);

    // Saturation keeps ovf set until the next start.
    ez_vec = '{$urandom, $urandom};
    hy_vec = '{32'h7FFF_FFFF};
    do_run(1, 32'h7FFF_FFFF, 32'h0, 0, 1'b0);
    repeat (4) @(negedge clk);
    #4;
    check("ovf_sticky", bus.ovf_o, 1);

    // Backpressure: 5-cycle output stall after the third result plus input gaps.
    ready_pct = 100;
    n_out_seen = 0;
    stall_after = 3;
    stall_armed = 1'b1;
    fill(8, 1'b0);
    do_run(8, $urandom_range(32'h1FFFF), $urandom_range(32'h1FFFF), 30, 1'b0);
    check("stall_happened", stall_armed, 0);

    // start_i while busy must not disturb the run.
    ready_pct = 80;
    fill(6, 1'b0);
    do_run(6, $urandom_range(32'h1FFFF), $urandom_range(32'h1FFFF), 20, 1'b1);

    // Random runs, narrow and full-range operands.
    for (int r = 0; r < 6; r++) begin
      int n;
      n = $urandom_range(1, 10);
      ready_pct = 60 + 10 * (r % 4);
      fill(n, r[0]);
      if (r[0]) do_run(n, $urandom, $urandom, 30, 1'b0);
      else      do_run(n, $urandom_range(32'h3FFFF), $urandom_range(32'h3FFFF), 30, 1'b0);
    end

    // Reset after 2 of 5 transfers, then a clean N=1 run.
    ready_pct = 100;
    @(negedge clk);
    bus.start_i   = 1'b1;
    bus.n_cells_i = CW'(5);
    bus.chyh_i    = 32'h10000;
    bus.chyez_i   = 32'h10000;
    @(negedge clk);
    bus.start_i    = 1'b0;
    bus.ez_valid_i = 1'b1;
    bus.hy_valid_i = 1'b1;
    bus.ez_data_i  = $urandom;
    bus.hy_data_i  = $urandom;
    hs = 0;
    for (int k = 0; k < 50; k++) begin
      #4;
      if (bus.hy_valid_i && bus.hy_ready_o) hs++;
      if (hs == 2) break;
      @(negedge clk);
      bus.ez_data_i = $urandom;
      bus.hy_data_i = $urandom;
    end
    check("partial_transfers", hs, 2);
    @(negedge clk);
    rst_n = 1'b0;
    bus.ez_valid_i = 1'b0;
    bus.hy_valid_i = 1'b0;
    #1;
    check("mid_rst_ez_ready", bus.ez_ready_o, 0);
    check("mid_rst_hy_ready", bus.hy_ready_o, 0);
    check("mid_rst_out_valid", bus.out_valid_o, 0);
    check("mid_rst_out_data", bus.out_data_o, 0);
    check("mid_rst_busy", bus.busy_o, 0);
    check("mid_rst_done", bus.done_o, 0);
    check("mid_rst_ovf", bus.ovf_o, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    #4;
    check("post_rst_no_done", bus.done_o, 0);
    fill(1, 1'b0);
    do_run(1, $urandom_range(32'h3FFFF), $urandom_range(32'h3FFFF), 0, 1'b0);

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
